// File: rtl/fisc_fetch_pkg.sv
// fisc_fetch_pkg
// Shared types and widths for the FISC instruction fetch stage.
// The width constants mirror FISC_INTEGER_SZ, FISC_INSTRUCTION_SZ and
// FISC_ADDRESS_BOOT_SZ from fisc_defines.sv so the fetch slice can be
// compiled on its own.
package fisc_fetch_pkg;

  localparam int FISC_INTEGER_SZ      = 64;
  localparam int FISC_INSTRUCTION_SZ  = 32;
  localparam int FISC_ADDRESS_BOOT_SZ = 32;

  // Fetch sequencing: issue a block read, wait out the memory latency,
  // then hand the two halves of the block to decode.
  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DELIVER = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fisc_fetch_block_buf.sv
// fisc_fetch_block_buf
// Holds the most recently fetched 64-bit block and selects which 32-bit
// instruction of it is presented to decode.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset (clears the block)
//   load     capture din into the block latch this cycle
//   din      block read data from memory channel a
//   sel      0: low half (PC[2]=0), 1: high half (PC[2]=1)
//   insn     selected instruction
module fisc_fetch_block_buf
  import fisc_fetch_pkg::*;
#(
  parameter int INT_W  = FISC_INTEGER_SZ,
  parameter int INSN_W = FISC_INSTRUCTION_SZ
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [INT_W-1:0]  din,
  input  logic              sel,
  output logic [INSN_W-1:0] insn
);

  logic [INT_W-1:0] block_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      block_q <= '0;
    end else if (load) begin
      block_q <= din;
    end
  end

  // A block is exactly two instructions wide.
  assign insn = sel ? block_q[2*INSN_W-1:INSN_W] : block_q[INSN_W-1:0];

endmodule

// File: rtl/fisc_fetch_unit.sv
// fisc_fetch_unit
// Instruction fetch stage ahead of FISC decode. Owns the PC, reads one
// 64-bit block per request on memory channel a and delivers its two
// instructions to decode over a valid/ready handshake. Redirects (branch
// targets, reset vector) are accepted in any state and flush the fetch.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   wait_n           0 holds off issuing a new block read
//   redirect_valid   load redirect_pc this cycle and flush
//   redirect_pc      new byte PC (low two bits dropped, misalign flagged)
//   dec_ready        decode can take an instruction
//   dec_valid        dec_insn/dec_pc carry a valid instruction
//   dec_insn         instruction
//   dec_pc           byte PC of dec_insn
//   rd_a             one-cycle read strobe on channel a
//   addr_bus_a       block address PC[ADDR_W+2:3]
//   din_bus_a        channel a read data
//   misalign         one-cycle pulse after a redirect with PC[1:0]!=0
//   busy             a block read is outstanding
module fisc_fetch_unit
  import fisc_fetch_pkg::*;
#(
  parameter int                         INT_W       = FISC_INTEGER_SZ,
  parameter int                         INSN_W      = FISC_INSTRUCTION_SZ,
  parameter int                         ADDR_W      = FISC_ADDRESS_BOOT_SZ,
  parameter int                         MEM_LATENCY = 1,
  parameter logic [FISC_INTEGER_SZ-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wait_n,
  input  logic              redirect_valid,
  input  logic [INT_W-1:0]  redirect_pc,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [INSN_W-1:0] dec_insn,
  output logic [INT_W-1:0]  dec_pc,
  output logic              rd_a,
  output logic [ADDR_W-1:0] addr_bus_a,
  input  logic [INT_W-1:0]  din_bus_a,
  output logic              misalign,
  output logic              busy
);

  // Data for a strobe in cycle N is valid from cycle N+1 onwards, so the
  // first ST_WAIT cycle (count 0) already sees it when MEM_LATENCY is 1.
  localparam logic [7:0] LAT_LAST = 8'(MEM_LATENCY - 1);

  fetch_state_t     state_q, state_d;
  logic [INT_W-1:0] pc_q, pc_d;
  logic [7:0]       lat_q, lat_d;
  logic             busy_q, busy_d;
  logic             misalign_q, misalign_d;
  logic             issue;
  logic             load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC[INT_W-1:0];
      lat_q      <= '0;
      busy_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      lat_q      <= lat_d;
      busy_q     <= busy_d;
      misalign_q <= misalign_d;
    end
  end

  // Redirect overrides everything, including an in-flight read (whose data
  // is simply never loaded) and a transfer completing this same cycle
  // (decode still takes it, but its PC increment is dropped).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lat_d      = lat_q;
    busy_d     = busy_q;
    issue      = 1'b0;
    load       = 1'b0;
    misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

    if (redirect_valid) begin
      state_d = ST_REQ;
      pc_d    = {redirect_pc[INT_W-1:2], 2'b00};
      lat_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (wait_n) begin
            issue   = 1'b1;
            lat_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_q == LAT_LAST) begin
            load    = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DELIVER;
          end else begin
            lat_d = lat_q + 8'd1;
          end
        end
        ST_DELIVER: begin
          // Low half accepted: the high half is already in the buffer.
          if (dec_ready) begin
            pc_d = pc_q + INT_W'(4);
            if (pc_q[2]) begin
              state_d = ST_REQ;
            end
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  fisc_fetch_block_buf #(
    .INT_W  (INT_W),
    .INSN_W (INSN_W)
  ) u_block_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .din     (din_bus_a),
    .sel     (pc_q[2]),
    .insn    (dec_insn)
  );

  // The strobe is decoded from the current state, so it is masked by
  // reset_n to keep the bus quiet while the core is held in reset.
  assign rd_a       = issue && reset_n;
  assign addr_bus_a = rd_a ? pc_q[ADDR_W+2:3] : '0;
  assign dec_valid  = (state_q == ST_DELIVER);
  assign dec_pc     = pc_q;
  assign busy       = busy_q;
  assign misalign   = misalign_q;

endmodule
